// File: rtl/mul_wb_arbiter.sv
// mul_wb_arbiter: shares the ROB writeback port between the 1-cycle ALU path and the
// multiplier pipeline. The multiplier cannot stall and always wins; a losing ALU result
// parks in a 1-entry skid buffer. A starvation counter raises mul_issue_hold so a parked
// ALU result eventually drains. Also tracks the number of multiplies in flight.
//
// Optional feature macro: WB_ARB_STATS_EN (adds stat_collisions / stat_hold_cycles).
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   flush               pipeline flush: drops inputs, clears skid/starve/inflight/hold
//   alu_*               ALU result (valid, result, rob_idx, exc)
//   mul_issue           a multiply enters M1 this cycle
//   mul_*               M5 multiplier result (valid, result, rob_idx, exc)
//   alu_stall           skid occupied; EX must hold its ALU result
//   mul_issue_hold      decode must not issue a multiply
//   mul_idle            no multiplies in flight
//   wb_*                registered ROB write port; wb_src_mul = 1 when MUL won
//   stat_*              (WB_ARB_STATS_EN only) collision and hold-cycle counters
module mul_wb_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned ROB_IDX_W    = 4,
    parameter int unsigned EXC_W        = 3,
    parameter int unsigned MUL_STAGES   = 5,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 alu_valid_in,
    input  logic [XLEN-1:0]      alu_result,
    input  logic [ROB_IDX_W-1:0] alu_rob_idx,
    input  logic [EXC_W-1:0]     alu_exc,
    input  logic                 mul_issue,
    input  logic                 mul_valid_in,
    input  logic [XLEN-1:0]      mul_result,
    input  logic [ROB_IDX_W-1:0] mul_rob_idx,
    input  logic [EXC_W-1:0]     mul_exc,
    output logic                 alu_stall,
    output logic                 mul_issue_hold,
    output logic                 mul_idle,
    output logic                 wb_valid,
    output logic [XLEN-1:0]      wb_result,
    output logic [ROB_IDX_W-1:0] wb_rob_idx,
    output logic [EXC_W-1:0]     wb_exc,
    output logic                 wb_src_mul
`ifdef WB_ARB_STATS_EN
    ,
    output logic [31:0]          stat_collisions,
    output logic [31:0]          stat_hold_cycles
`endif
);

    localparam int unsigned INF_W    = $clog2(MUL_STAGES + 1);
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [XLEN-1:0]      result;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [EXC_W-1:0]     exc;
    } payload_t;

    typedef enum logic {
        SKID_EMPTY = 1'b0,
        SKID_FULL  = 1'b1
    } skid_state_t;

    skid_state_t          skid_state, skid_state_next;
    payload_t             skid_q, skid_d;
    payload_t             wb_q, wb_d;
    payload_t             alu_p, mul_p;
    logic [STARVE_W-1:0]  starve_cnt, starve_next;
    logic [INF_W-1:0]     inflight, inflight_next;
    logic                 wb_valid_next;
    logic                 wb_src_mul_next;
    logic                 hold_next;
    logic                 idle_next;

    assign alu_p = {alu_result, alu_rob_idx, alu_exc};
    assign mul_p = {mul_result, mul_rob_idx, mul_exc};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            skid_state     <= SKID_EMPTY;
            skid_q         <= '0;
            wb_q           <= '0;
            starve_cnt     <= '0;
            inflight       <= '0;
            wb_valid       <= 1'b0;
            wb_src_mul     <= 1'b0;
            mul_issue_hold <= 1'b0;
            mul_idle       <= 1'b1;
        end else begin
            skid_state     <= skid_state_next;
            skid_q         <= skid_d;
            wb_q           <= wb_d;
            starve_cnt     <= starve_next;
            inflight       <= inflight_next;
            wb_valid       <= wb_valid_next;
            wb_src_mul     <= wb_src_mul_next;
            mul_issue_hold <= hold_next;
            mul_idle       <= idle_next;
        end
    end

    // Winner selection, skid control, starvation and in-flight tracking
    always_comb begin
        skid_state_next = skid_state;
        skid_d          = skid_q;
        wb_d            = wb_q;
        wb_valid_next   = 1'b0;
        wb_src_mul_next = wb_src_mul;
        starve_next     = starve_cnt;
        inflight_next   = inflight;

        if (flush) begin
            skid_state_next = SKID_EMPTY;
            starve_next     = '0;
            inflight_next   = '0;
        end else begin
            if (mul_valid_in) begin
                wb_valid_next   = 1'b1;
                wb_d            = mul_p;
                wb_src_mul_next = 1'b1;
                if (skid_state == SKID_FULL) begin
                    if (starve_cnt != STARVE_W'(STARVE_LIMIT))
                        starve_next = starve_cnt + STARVE_W'(1);
                end else if (alu_valid_in) begin
                    skid_state_next = SKID_FULL;
                    skid_d          = alu_p;
                end
            end else if (skid_state == SKID_FULL) begin
                wb_valid_next   = 1'b1;
                wb_d            = skid_q;
                wb_src_mul_next = 1'b0;
                skid_state_next = SKID_EMPTY;
                starve_next     = '0;
            end else if (alu_valid_in) begin
                wb_valid_next   = 1'b1;
                wb_d            = alu_p;
                wb_src_mul_next = 1'b0;
            end

            // Saturating count; simultaneous issue and completion cancel out
            if (mul_issue && !mul_valid_in) begin
                if (inflight != INF_W'(MUL_STAGES))
                    inflight_next = inflight + INF_W'(1);
            end else if (!mul_issue && mul_valid_in) begin
                if (inflight != '0)
                    inflight_next = inflight - INF_W'(1);
            end
        end

        // starve_next only climbs while the skid stays full, so hold drops with the drain
        hold_next = !flush && (starve_next == STARVE_W'(STARVE_LIMIT));
        idle_next = (inflight_next == '0);
    end

    assign alu_stall  = (skid_state == SKID_FULL);
    assign wb_result  = wb_q.result;
    assign wb_rob_idx = wb_q.rob_idx;
    assign wb_exc     = wb_q.exc;

`ifdef WB_ARB_STATS_EN
    // Free-running statistics; only reset clears them
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_collisions  <= '0;
            stat_hold_cycles <= '0;
        end else begin
            if (mul_valid_in && alu_valid_in)
                stat_collisions <= stat_collisions + 32'd1;
            if (mul_issue_hold)
                stat_hold_cycles <= stat_hold_cycles + 32'd1;
        end
    end
`endif

    // Protocol checks: ALU must hold while stalled; in-flight count must stay in range
    a_alu_while_stall: assert property (@(posedge clk) disable iff (reset || flush)
        !(alu_valid_in && alu_stall));
    a_inflight_over: assert property (@(posedge clk) disable iff (reset || flush)
        !(mul_issue && !mul_valid_in && inflight == INF_W'(MUL_STAGES)));
    a_inflight_under: assert property (@(posedge clk) disable iff (reset || flush)
        !(mul_valid_in && !mul_issue && inflight == '0));

endmodule

// File: tb/tb_mul_wb_arbiter.sv
// Testbench for mul_wb_arbiter: directed vector table, multi-cycle corner sequences
// and randomized traffic checked against a queue/integer reference model.
module tb_mul_wb_arbiter;

    localparam int MUL_STAGES   = 5;
    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic        alu_valid_in, mul_issue, mul_valid_in;
    logic [31:0] alu_result, mul_result;
    logic [3:0]  alu_rob_idx, mul_rob_idx;
    logic [2:0]  alu_exc, mul_exc;
    logic        alu_stall, mul_issue_hold, mul_idle;
    logic        wb_valid, wb_src_mul;
    logic [31:0] wb_result;
    logic [3:0]  wb_rob_idx;
    logic [2:0]  wb_exc;
`ifdef WB_ARB_STATS_EN
    logic [31:0] stat_collisions, stat_hold_cycles;
`endif

    always #5 clk = ~clk;

    mul_wb_arbiter dut (
        .clk(clk), .reset(reset), .flush(flush),
        .alu_valid_in(alu_valid_in), .alu_result(alu_result),
        .alu_rob_idx(alu_rob_idx), .alu_exc(alu_exc),
        .mul_issue(mul_issue), .mul_valid_in(mul_valid_in),
        .mul_result(mul_result), .mul_rob_idx(mul_rob_idx), .mul_exc(mul_exc),
        .alu_stall(alu_stall), .mul_issue_hold(mul_issue_hold), .mul_idle(mul_idle),
        .wb_valid(wb_valid), .wb_result(wb_result), .wb_rob_idx(wb_rob_idx),
        .wb_exc(wb_exc), .wb_src_mul(wb_src_mul)
`ifdef WB_ARB_STATS_EN
        , .stat_collisions(stat_collisions), .stat_hold_cycles(stat_hold_cycles)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    typedef struct {
        logic [31:0] res;
        logic [3:0]  idx;
        logic [2:0]  exc;
    } entry_t;

    entry_t skid_q[$];
    entry_t m_wb;
    logic   m_wb_valid, m_src;
    int     m_starve, m_inflight;
    logic   m_hold;
    longint m_coll, m_holdcyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic set_in(input logic r, input logic f, input logic av, input logic [31:0] ar,
                          input logic [3:0] ai, input logic mi, input logic mv,
                          input logic [31:0] mr, input logic [3:0] mx);
        reset = r; flush = f;
        alu_valid_in = av; alu_result = ar; alu_rob_idx = ai; alu_exc = 3'd1;
        mul_issue = mi; mul_valid_in = mv; mul_result = mr; mul_rob_idx = mx; mul_exc = 3'd2;
    endtask

    // Advance the model by one clock using the currently driven inputs
    task automatic model_step();
        entry_t a, m;
        a.res = alu_result; a.idx = alu_rob_idx; a.exc = alu_exc;
        m.res = mul_result; m.idx = mul_rob_idx; m.exc = mul_exc;
        if (reset) begin
            skid_q.delete();
            m_wb = '{32'd0, 4'd0, 3'd0};
            m_wb_valid = 1'b0; m_src = 1'b0;
            m_starve = 0; m_inflight = 0; m_hold = 1'b0;
            m_coll = 0; m_holdcyc = 0;
        end else begin
            if (mul_valid_in && alu_valid_in) m_coll++;
            if (m_hold) m_holdcyc++;
            m_wb_valid = 1'b0;
            if (flush) begin
                skid_q.delete();
                m_starve = 0; m_inflight = 0; m_hold = 1'b0;
            end else begin
                if (mul_valid_in) begin
                    m_wb = m; m_wb_valid = 1'b1; m_src = 1'b1;
                    if (skid_q.size() != 0) m_starve = (m_starve + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_starve + 1;
                    else if (alu_valid_in) skid_q.push_back(a);
                end else if (skid_q.size() != 0) begin
                    m_wb = skid_q.pop_front(); m_wb_valid = 1'b1; m_src = 1'b0;
                    m_starve = 0;
                end else if (alu_valid_in) begin
                    m_wb = a; m_wb_valid = 1'b1; m_src = 1'b0;
                end
                m_inflight = m_inflight + int'(mul_issue) - int'(mul_valid_in);
                if (m_inflight < 0) m_inflight = 0;
                if (m_inflight > MUL_STAGES) m_inflight = MUL_STAGES;
                m_hold = (m_starve == STARVE_LIMIT);
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".wb_valid"}, 64'(wb_valid), 64'(m_wb_valid));
        if (m_wb_valid) begin
            chk({tag, ".wb_result"}, 64'(wb_result), 64'(m_wb.res));
            chk({tag, ".wb_rob_idx"}, 64'(wb_rob_idx), 64'(m_wb.idx));
            chk({tag, ".wb_exc"}, 64'(wb_exc), 64'(m_wb.exc));
            chk({tag, ".wb_src_mul"}, 64'(wb_src_mul), 64'(m_src));
        end
        chk({tag, ".alu_stall"}, 64'(alu_stall), 64'(skid_q.size() != 0));
        chk({tag, ".hold"}, 64'(mul_issue_hold), 64'(m_hold));
        chk({tag, ".mul_idle"}, 64'(mul_idle), 64'(m_inflight == 0));
`ifdef WB_ARB_STATS_EN
        chk({tag, ".stat_coll"}, 64'(stat_collisions), 64'(m_coll));
        chk({tag, ".stat_hold"}, 64'(stat_hold_cycles), 64'(m_holdcyc));
`endif
    endtask

    typedef struct {
        logic        rst, fl, av;
        logic [31:0] ar;
        logic [3:0]  ai;
        logic        mi, mv;
        logic [31:0] mr;
        logic [3:0]  mx;
        logic        e_valid;
        logic [31:0] e_res;
        logic [3:0]  e_idx;
        logic [2:0]  e_exc;
        logic        e_src, e_stall, e_hold, e_idle;
    } vec_t;

    vec_t tbl[9];

    initial begin
        // rst fl av ar ai | mi mv mr mx | valid res idx exc src stall hold idle
        tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0,  4'h0, 1'b0, 1'b0, 32'h0,  4'h0, 1'b0, 32'h0,  4'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 32'h11, 4'h3, 1'b0, 1'b0, 32'h0,  4'h0, 1'b1, 32'h11, 4'h3, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 32'h0,  4'h0, 1'b1, 1'b0, 32'h0,  4'h0, 1'b0, 32'h11, 4'h3, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 32'h66, 4'h6, 1'b0, 1'b1, 32'h55, 4'h5, 1'b1, 32'h55, 4'h5, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 32'h0,  4'h0, 1'b0, 1'b0, 32'h0,  4'h0, 1'b1, 32'h66, 4'h6, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 32'h0,  4'h0, 1'b0, 1'b0, 32'h0,  4'h0, 1'b0, 32'h66, 4'h6, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 32'h0,  4'h0, 1'b1, 1'b0, 32'h0,  4'h0, 1'b0, 32'h66, 4'h6, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 32'h0,  4'h0, 1'b1, 1'b1, 32'h77, 4'h7, 1'b1, 32'h77, 4'h7, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 32'h0,  4'h0, 1'b0, 1'b1, 32'h88, 4'h8, 1'b1, 32'h88, 4'h8, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1};

        set_in(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 4'h0);
        @(posedge clk); #1;

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            set_in(tbl[i].rst, tbl[i].fl, tbl[i].av, tbl[i].ar, tbl[i].ai,
                   tbl[i].mi, tbl[i].mv, tbl[i].mr, tbl[i].mx);
            cycle();
            chk($sformatf("vec%0d.wb_valid", i), 64'(wb_valid), 64'(tbl[i].e_valid));
            chk($sformatf("vec%0d.wb_result", i), 64'(wb_result), 64'(tbl[i].e_res));
            chk($sformatf("vec%0d.wb_rob_idx", i), 64'(wb_rob_idx), 64'(tbl[i].e_idx));
            chk($sformatf("vec%0d.wb_exc", i), 64'(wb_exc), 64'(tbl[i].e_exc));
            chk($sformatf("vec%0d.wb_src_mul", i), 64'(wb_src_mul), 64'(tbl[i].e_src));
            chk($sformatf("vec%0d.alu_stall", i), 64'(alu_stall), 64'(tbl[i].e_stall));
            chk($sformatf("vec%0d.hold", i), 64'(mul_issue_hold), 64'(tbl[i].e_hold));
            chk($sformatf("vec%0d.mul_idle", i), 64'(mul_idle), 64'(tbl[i].e_idle));
        end

        // Starvation: fill pipe, park an ALU result, starve it with 4 more completions
        set_in(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 4'h0); cycle();
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 4'h0); cycle();
            chk($sformatf("issue%0d.mul_idle", i), 64'(mul_idle), 64'd0);
        end
        set_in(1'b0, 1'b0, 1'b1, 32'hA1A1, 4'hA, 1'b0, 1'b1, 32'hB0, 4'h1); cycle();
        chk("park.alu_stall", 64'(alu_stall), 64'd1);
        cmp_model("park");
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'hB1 + 32'(i), 4'(2 + i)); cycle();
            chk($sformatf("starve%0d.hold", i), 64'(mul_issue_hold), (i == 3) ? 64'd1 : 64'd0);
            chk($sformatf("starve%0d.mul_idle", i), 64'(mul_idle), (i == 3) ? 64'd1 : 64'd0);
            cmp_model($sformatf("starve%0d", i));
        end
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 4'h0); cycle();
        chk("drain.wb_valid", 64'(wb_valid), 64'd1);
        chk("drain.wb_result", 64'(wb_result), 64'hA1A1);
        chk("drain.wb_rob_idx", 64'(wb_rob_idx), 64'hA);
        chk("drain.alu_stall", 64'(alu_stall), 64'd0);
        chk("drain.hold", 64'(mul_issue_hold), 64'd0);

        // Flush with skid full, inflight 3, hold set
        set_in(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 4'h0); cycle();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 4'h0); cycle();
        end
        set_in(1'b0, 1'b0, 1'b1, 32'hC3, 4'hC, 1'b0, 1'b1, 32'hD0, 4'hD); cycle();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b1, 32'hD1, 4'hE); cycle();
        end
        chk("preflush.hold", 64'(mul_issue_hold), 64'd1);
        chk("preflush.alu_stall", 64'(alu_stall), 64'd1);
        chk("preflush.mul_idle", 64'(mul_idle), 64'd0);
        set_in(1'b0, 1'b1, 1'b1, 32'hEE, 4'hF, 1'b1, 1'b1, 32'hFF, 4'hF); cycle();
        chk("flush.wb_valid", 64'(wb_valid), 64'd0);
        chk("flush.alu_stall", 64'(alu_stall), 64'd0);
        chk("flush.hold", 64'(mul_issue_hold), 64'd0);
        chk("flush.mul_idle", 64'(mul_idle), 64'd1);
        cmp_model("flush");

        // Reset mid-traffic
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 4'h0); cycle();
        set_in(1'b0, 1'b0, 1'b1, 32'h12, 4'h2, 1'b1, 1'b1, 32'h34, 4'h4); cycle();
        set_in(1'b1, 1'b0, 1'b1, 32'h56, 4'h6, 1'b1, 1'b1, 32'h78, 4'h8); cycle();
        chk("rst.wb_valid", 64'(wb_valid), 64'd0);
        chk("rst.wb_result", 64'(wb_result), 64'd0);
        chk("rst.wb_rob_idx", 64'(wb_rob_idx), 64'd0);
        chk("rst.wb_src_mul", 64'(wb_src_mul), 64'd0);
        chk("rst.alu_stall", 64'(alu_stall), 64'd0);
        chk("rst.hold", 64'(mul_issue_hold), 64'd0);
        chk("rst.mul_idle", 64'(mul_idle), 64'd1);
`ifdef WB_ARB_STATS_EN
        chk("rst.stat_coll", 64'(stat_collisions), 64'd0);
        chk("rst.stat_hold", 64'(stat_hold_cycles), 64'd0);
`endif

        // Randomized traffic honouring the stall / hold / in-flight protocol
        for (int n = 0; n < 3000; n++) begin
            logic r, f, av, mv, mi;
            r  = ($urandom_range(0, 299) == 0);
            f  = ($urandom_range(0, 63) == 0);
            av = (skid_q.size() == 0) && ($urandom_range(0, 1) == 1);
            mv = (m_inflight > 0) && ($urandom_range(0, 2) != 0);
            mi = !m_hold && (m_inflight < MUL_STAGES || mv) && ($urandom_range(0, 1) == 1);
            set_in(r, f, av, $urandom, 4'($urandom), mi, mv, $urandom, 4'($urandom));
            alu_exc = 3'($urandom);
            mul_exc = 3'($urandom);
            cycle();
            cmp_model("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
